mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 97 +++++++++
 tb/tb_mem_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (cpu, dbg) round-robin arbiter in front of a fixed-latency memory.
// One transaction at a time: IDLE -> ACCESS (LAT cycles) -> DONE -> IDLE.
module mem_arbiter #(
   parameter int LAT = 2,
   parameter int AW  = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_adr,
   input  logic [31:0]   cpu_wd,
   output logic [31:0]   cpu_rd,
   output logic          cpu_ready,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_adr,
   input  logic [31:0]   dbg_wd,
   output logic [31:0]   dbg_rd,
   output logic          dbg_ready,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_adr,
   output logic [31:0]   mem_wd,
   input  logic [31:0]   mem_rd,
   output logic [1:0]    state
);

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] ACCESS = 2'b01;
   localparam logic [1:0] DONE   = 2'b10;
   localparam logic [3:0] LAST   = 4'(LAT - 1);

   logic [1:0]    st;
   logic [3:0]    cnt;
   logic          ptr;
   logic          own;
   logic          we_q;
   logic [AW-1:0] adr_q;
   logic [31:0]   wd_q;
   logic [31:0]   data_q;
   logic          any_req;
   logic          gnt_dbg;

   // ptr/own: 1 = dbg, 0 = cpu. On a tie the port not granted last wins.
   assign any_req = cpu_req | dbg_req;
   assign gnt_dbg = dbg_req & (~cpu_req | ~ptr);

   always_ff @(posedge clk) begin
      if (reset) begin
         st     <= IDLE;
         cnt    <= '0;
         ptr    <= 1'b1;
         own    <= 1'b0;
         we_q   <= 1'b0;
         adr_q  <= '0;
         wd_q   <= '0;
         data_q <= '0;
      end else begin
         case (st)
            IDLE: begin
               if (any_req) begin
                  st    <= ACCESS;
                  cnt   <= LAST;
                  own   <= gnt_dbg;
                  ptr   <= gnt_dbg;
                  we_q  <= gnt_dbg ? dbg_we  : cpu_we;
                  adr_q <= gnt_dbg ? dbg_adr : cpu_adr;
                  wd_q  <= gnt_dbg ? dbg_wd  : cpu_wd;
               end
            end
            ACCESS: begin
               if (cnt == 4'd0) begin
                  st <= DONE;
                  if (!we_q) data_q <= mem_rd;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE:    st <= IDLE;
            default: st <= IDLE;
         endcase
      end
   end

   // Reset masks the strobes in the same cycle so an aborted access never completes.
   assign mem_en    = ~reset & (st == ACCESS);
   assign mem_we    = mem_en & we_q;
   assign mem_adr   = adr_q;
   assign mem_wd    = wd_q;
   assign cpu_ready = ~reset & (st == DONE) & ~own;
   assign dbg_ready = ~reset & (st == DONE) & own;
   assign cpu_rd    = data_q;
   assign dbg_rd    = data_q;
   assign state     = st;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (LAT=1,2,3) on shared stimulus,
// checked every cycle against a transaction-level model plus directed cases.
module tb_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic        dbg_req = 1'b0, dbg_we = 1'b0;
   logic [31:0] cpu_adr = '0, cpu_wd = '0;
   logic [31:0] dbg_adr = '0, dbg_wd = '0;
   logic [31:0] mem_rd = '0;

   logic [31:0] cpu_rd[3], dbg_rd[3], mem_adr[3], mem_wd[3];
   logic [1:0]  state[3];
   logic [2:0]  cpu_ready, dbg_ready, mem_en, mem_we;

   int errors = 0;
   int checks = 0;
   bit live = 0;

   for (genvar g = 0; g < 3; g++) begin : dut
      mem_arbiter #(.LAT(g + 1), .AW(32)) u (
         .clk(clk), .reset(reset),
         .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr),
         .cpu_wd(cpu_wd), .cpu_rd(cpu_rd[g]), .cpu_ready(cpu_ready[g]),
         .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr),
         .dbg_wd(dbg_wd), .dbg_rd(dbg_rd[g]), .dbg_ready(dbg_ready[g]),
         .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_adr(mem_adr[g]),
         .mem_wd(mem_wd[g]), .mem_rd(mem_rd), .state(state[g])
      );
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Model: rem = cycles left in the transaction (ACCESS cycles, then DONE).
   int          rem[3];
   bit          own_m[3], last_m[3], we_m[3];
   logic [31:0] adr_m[3], wd_m[3], data_m[3];

   initial begin
      for (int k = 0; k < 3; k++) begin
         rem[k] = 0; own_m[k] = 0; last_m[k] = 1; we_m[k] = 0;
         adr_m[k] = '0; wd_m[k] = '0; data_m[k] = '0;
      end
   end

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (reset) begin
            rem[k] = 0; last_m[k] = 1; data_m[k] = '0;
         end else if (rem[k] > 0) begin
            if (rem[k] == 2 && !we_m[k]) data_m[k] = mem_rd;
            rem[k]--;
         end else if (cpu_req || dbg_req) begin
            if (cpu_req && dbg_req) own_m[k] = !last_m[k];
            else own_m[k] = dbg_req;
            last_m[k] = own_m[k];
            we_m[k]  = own_m[k] ? dbg_we  : cpu_we;
            adr_m[k] = own_m[k] ? dbg_adr : cpu_adr;
            wd_m[k]  = own_m[k] ? dbg_wd  : cpu_wd;
            rem[k]   = k + 2;
         end
      end
   end

   logic       e_en;
   logic [1:0] e_st;
   always @(negedge clk) begin
      if (live) begin
         for (int k = 0; k < 3; k++) begin
            e_en = !reset && rem[k] >= 2;
            e_st = (rem[k] == 0) ? 2'b00 : (rem[k] >= 2) ? 2'b01 : 2'b10;
            chk($sformatf("m%0d.state", k), state[k], e_st);
            chk($sformatf("m%0d.mem_en", k), mem_en[k], e_en);
            chk($sformatf("m%0d.mem_we", k), mem_we[k], e_en && we_m[k]);
            if (e_en) begin
               chk($sformatf("m%0d.mem_adr", k), mem_adr[k], adr_m[k]);
               chk($sformatf("m%0d.mem_wd", k), mem_wd[k], wd_m[k]);
            end
            chk($sformatf("m%0d.cpu_ready", k), cpu_ready[k],
                !reset && rem[k] == 1 && !own_m[k]);
            chk($sformatf("m%0d.dbg_ready", k), dbg_ready[k],
                !reset && rem[k] == 1 && own_m[k]);
            chk($sformatf("m%0d.cpu_rd", k), cpu_rd[k], data_m[k]);
            chk($sformatf("m%0d.dbg_rd", k), dbg_rd[k], data_m[k]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rst();
      reset = 1; cpu_req = 0; dbg_req = 0; cpu_we = 0; dbg_we = 0;
      repeat (2) step();
      reset = 0;
   endtask

   initial begin
      step();
      live = 1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst.state", state[k], 0);
         chk("rst.mem_en", mem_en[k], 0);
         chk("rst.ready", {cpu_ready[k], dbg_ready[k]}, 0);
         chk("rst.rd", cpu_rd[k], 0);
      end

      // LAT=2 cpu read
      rst();
      cpu_req = 1; cpu_adr = 32'h10; mem_rd = 32'hDEADBEEF;
      step(); @(negedge clk);
      chk("rd.en_c2", mem_en[1], 1);
      chk("rd.adr_c2", mem_adr[1], 32'h10);
      step(); @(negedge clk);
      chk("rd.en_c3", mem_en[1], 1);
      chk("rd.rdy_c3", cpu_ready[1], 0);
      step(); cpu_req = 0; @(negedge clk);
      chk("rd.rdy_c4", cpu_ready[1], 1);
      chk("rd.data_c4", cpu_rd[1], 32'hDEADBEEF);
      chk("rd.dbg_c4", dbg_ready[1], 0);
      step(); @(negedge clk);
      chk("rd.en_c5", mem_en[1], 0);
      chk("rd.rdy_c5", cpu_ready[1], 0);

      // LAT=2 dbg write
      rst();
      dbg_req = 1; dbg_we = 1; dbg_adr = 32'h20; dbg_wd = 32'h12345678;
      for (int n = 2; n <= 3; n++) begin
         step(); @(negedge clk);
         chk("wr.we", mem_we[1], 1);
         chk("wr.adr", mem_adr[1], 32'h20);
         chk("wr.wd", mem_wd[1], 32'h12345678);
         chk("wr.rdy_early", dbg_ready[1], 0);
      end
      step(); dbg_req = 0; @(negedge clk);
      chk("wr.rdy", dbg_ready[1], 1);
      chk("wr.en_done", mem_en[1], 0);
      chk("wr.cpu_rdy", cpu_ready[1], 0);
      step(); @(negedge clk);
      chk("wr.rdy_once", dbg_ready[1], 0);

      // LAT=1: requester changes and drops during ACCESS
      rst();
      cpu_req = 1; cpu_we = 0; cpu_adr = 32'h40; mem_rd = 32'h0BADF00D;
      step(); cpu_req = 0; cpu_adr = 32'h99; @(negedge clk);
      chk("l1.en", mem_en[0], 1);
      chk("l1.adr", mem_adr[0], 32'h40);
      step(); @(negedge clk);
      chk("l1.rdy_c3", cpu_ready[0], 1);
      chk("l1.data", cpu_rd[0], 32'h0BADF00D);

      // LAT=3: reset on the second ACCESS cycle
      rst();
      cpu_req = 1; cpu_adr = 32'h10; dbg_adr = 32'h20;
      step(); step(); reset = 1;
      step(); reset = 0; cpu_req = 1; dbg_req = 1; @(negedge clk);
      chk("ab.state", state[2], 0);
      chk("ab.en", mem_en[2], 0);
      chk("ab.rdy", cpu_ready[2], 0);
      step(); cpu_req = 0; dbg_req = 0; @(negedge clk);
      chk("ab.state_acc", state[2], 1);
      chk("ab.tie_cpu", mem_adr[2], 32'h10);
      repeat (3) step();
      @(negedge clk);
      chk("ab.rdy_new", cpu_ready[2], 1);

      // LAT=2: held tie alternates cpu, dbg, cpu with an IDLE gap
      rst();
      cpu_req = 1; dbg_req = 1; cpu_adr = 32'h100; dbg_adr = 32'h200;
      for (int n = 2; n <= 13; n++) begin
         step(); @(negedge clk);
         if (n % 4 == 0) begin
            chk("rr.cpu", cpu_ready[1], ((n / 4) % 2) == 1);
            chk("rr.dbg", dbg_ready[1], ((n / 4) % 2) == 0);
         end
         if (n % 4 == 1) chk("rr.idle", state[1], 0);
      end
      cpu_req = 0; dbg_req = 0;

      for (int i = 0; i < 3000; i++) begin
         step();
         reset   = ($urandom_range(0, 99) == 0);
         cpu_req = ($urandom_range(0, 2) != 0);
         dbg_req = ($urandom_range(0, 2) != 0);
         cpu_we  = $urandom_range(0, 1) == 1;
         dbg_we  = $urandom_range(0, 1) == 1;
         cpu_adr = $urandom; cpu_wd = $urandom;
         dbg_adr = $urandom; dbg_wd = $urandom;
         mem_rd  = $urandom;
      end
      reset = 0; cpu_req = 0; dbg_req = 0;
      repeat (8) step();
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
